// File: rtl/alu_decoder_pkg.sv
// rtl/alu_decoder_pkg.sv - shared ALU opcodes, RV32I opcodes and decode types
package alu_decoder_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_BUF  = 4'd10,
    ALU_EQ   = 4'd11,
    ALU_GE   = 4'd12,
    ALU_GEU  = 4'd13
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    alu_op_e     alu_ctrl;
    logic        op1_pc;
    logic        op2_imm;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        branch;
    logic        jump;
    logic        br_invert;
    logic [2:0]  funct3;
    logic        illegal;
  } bundle_t;

  // Shared by OP and OP-IMM; alt is insn[30] and only matters where the caller allows it.
  function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder_imm_gen.sv
// rtl/alu_decoder_imm_gen.sv - RV32I immediate extraction and sign extension
module imm_gen
  import alu_decoder_pkg::*;
(
  input  logic [31:0] insn,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    case (fmt)
      IMM_I:   imm = {{20{insn[31]}}, insn[31:20]};
      IMM_S:   imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      IMM_B:   imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      IMM_U:   imm = {insn[31:12], 12'b0};
      IMM_J:   imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default: imm = 32'b0;
    endcase
  end

endmodule

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - single-entry registered RV32I decode stage
// Optional illegal-instruction flagging: define DECODE_ILLEGAL_EN.
module alu_decoder
  import alu_decoder_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_insn,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  input  logic        i_ex_ready,
  input  logic        i_flush,
  output logic [3:0]  o_alu_ctrl,
  output logic        o_op1_pc,
  output logic        o_op2_imm,
  output logic [31:0] o_imm,
  output logic [31:0] o_pc,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_reg_wr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic        o_branch,
  output logic        o_jump,
  output logic        o_br_invert,
  output logic [2:0]  o_funct3,
  output logic        o_illegal
);

  logic        valid_q, valid_d;
  bundle_t     bundle_q, bundle_d;
  bundle_t     dec;
  imm_fmt_e    fmt;
  logic [31:0] imm;
  logic        capture;

  wire [6:0] opcode = i_insn[6:0];
  wire [2:0] funct3 = i_insn[14:12];

  imm_gen u_imm_gen (
    .insn (i_insn),
    .fmt  (fmt),
    .imm  (imm)
  );

  always_comb begin
    dec           = '0;
    dec.alu_ctrl  = ALU_ADD;
    dec.pc        = i_pc;
    dec.rs1       = i_insn[19:15];
    dec.rs2       = i_insn[24:20];
    dec.rd        = i_insn[11:7];
    dec.funct3    = funct3;
    fmt           = IMM_NONE;
    case (opcode)
      OPC_OP: begin
        dec.alu_ctrl = arith_op(funct3, i_insn[30]);
        dec.reg_wr   = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only shifts use insn[30]; for addi it is just an immediate bit.
        dec.alu_ctrl = arith_op(funct3, i_insn[30] & (funct3 == 3'b101));
        dec.op2_imm  = 1'b1;
        dec.reg_wr   = 1'b1;
        fmt          = IMM_I;
      end
      OPC_LOAD: begin
        dec.op2_imm = 1'b1;
        dec.mem_rd  = 1'b1;
        dec.reg_wr  = 1'b1;
        fmt         = IMM_I;
      end
      OPC_STORE: begin
        dec.op2_imm = 1'b1;
        dec.mem_wr  = 1'b1;
        fmt         = IMM_S;
      end
      OPC_LUI: begin
        dec.alu_ctrl = ALU_BUF;
        dec.op2_imm  = 1'b1;
        dec.reg_wr   = 1'b1;
        fmt          = IMM_U;
      end
      OPC_AUIPC: begin
        dec.op1_pc  = 1'b1;
        dec.op2_imm = 1'b1;
        dec.reg_wr  = 1'b1;
        fmt         = IMM_U;
      end
      OPC_JAL: begin
        dec.op1_pc  = 1'b1;
        dec.op2_imm = 1'b1;
        dec.jump    = 1'b1;
        dec.reg_wr  = 1'b1;
        fmt         = IMM_J;
      end
      OPC_JALR: begin
        dec.op2_imm = 1'b1;
        dec.jump    = 1'b1;
        dec.reg_wr  = 1'b1;
        fmt         = IMM_I;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        fmt        = IMM_B;
        case (funct3)
          3'b000:  dec.alu_ctrl = ALU_EQ;
          3'b001: begin
            dec.alu_ctrl  = ALU_EQ;
            dec.br_invert = 1'b1;
          end
          3'b100:  dec.alu_ctrl = ALU_SLT;
          3'b101:  dec.alu_ctrl = ALU_GE;
          3'b110:  dec.alu_ctrl = ALU_SLTU;
          3'b111:  dec.alu_ctrl = ALU_GEU;
          default: dec.alu_ctrl = ALU_ADD;
        endcase
      end
      default: ;
    endcase
    dec.imm = imm;
    if (dec.rd == 5'd0) dec.reg_wr = 1'b0;
`ifdef DECODE_ILLEGAL_EN
    dec.illegal = (i_insn[1:0] != 2'b11)
                | !(opcode inside {OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_LUI,
                                   OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH})
                | ((opcode == OPC_OP) && (i_insn[31:25] != 7'h00) && (i_insn[31:25] != 7'h20))
                | ((opcode == OPC_OP) && (i_insn[31:25] == 7'h20)
                   && (funct3 != 3'b000) && (funct3 != 3'b101))
                | ((opcode == OPC_BRANCH) && (funct3[2:1] == 2'b01));
    if (dec.illegal) begin
      dec.reg_wr = 1'b0;
      dec.mem_rd = 1'b0;
      dec.mem_wr = 1'b0;
      dec.branch = 1'b0;
      dec.jump   = 1'b0;
    end
`else
    dec.illegal = 1'b0;
`endif
  end

  assign o_ready = ~valid_q | i_ex_ready;
  assign capture = i_valid & o_ready & ~i_flush;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (i_ex_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q           <= 1'b0;
      bundle_q          <= '0;
      bundle_q.alu_ctrl <= ALU_ADD;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_alu_ctrl  = bundle_q.alu_ctrl;
  assign o_op1_pc    = bundle_q.op1_pc;
  assign o_op2_imm   = bundle_q.op2_imm;
  assign o_imm       = bundle_q.imm;
  assign o_pc        = bundle_q.pc;
  assign o_rs1       = bundle_q.rs1;
  assign o_rs2       = bundle_q.rs2;
  assign o_rd        = bundle_q.rd;
  assign o_reg_wr    = bundle_q.reg_wr;
  assign o_mem_rd    = bundle_q.mem_rd;
  assign o_mem_wr    = bundle_q.mem_wr;
  assign o_branch    = bundle_q.branch;
  assign o_jump      = bundle_q.jump;
  assign o_br_invert = bundle_q.br_invert;
  assign o_funct3    = bundle_q.funct3;
  assign o_illegal   = bundle_q.illegal;

endmodule
